// File: rtl/ov7642_capture_ctrl_if.sv
// Camera, control and frame-buffer signals of the OV7642 capture controller.
interface ov7642_capture_ctrl_if #(
  parameter int unsigned ADDR_W = 19
) ();
  logic              vsync;
  logic              href;
  logic [7:0]        data;
  logic              start;
  logic              abort;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              busy;
  logic              done;
  logic              err_line;
  logic              err_frame;

  // Camera/host side: drives sensor stream and control, observes buffer writes.
  modport master (
    output vsync, href, data, start, abort,
    input  wr_en, wr_addr, wr_data, busy, done, err_line, err_frame
  );

  // Capture controller side.
  modport slave (
    input  vsync, href, data, start, abort,
    output wr_en, wr_addr, wr_data, busy, done, err_line, err_frame
  );
endinterface

// File: rtl/ov7642_capture_ctrl.sv
// Single-frame Y-only capture from an OV7642 byte stream into a frame buffer.
module ov7642_capture_ctrl #(
  parameter int unsigned WIDTH  = 640,
  parameter int unsigned HEIGHT = 480,
  parameter int unsigned ADDR_W = 19
) (
  input  logic                  pclk,
  input  logic                  n_rst,
  ov7642_capture_ctrl_if.slave  bus
);

  localparam int unsigned COL_W = $clog2(WIDTH + 1);
  localparam int unsigned ROW_W = $clog2(HEIGHT + 1);

  // Whole frame must be addressable.
  generate
    if ((longint'(WIDTH) * longint'(HEIGHT)) > (longint'(1) << ADDR_W)) begin : g_addr_check
      $error("ov7642_capture_ctrl: WIDTH*HEIGHT-1 does not fit ADDR_W");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARM     = 3'd1,
    SYNC    = 3'd2,
    CAPTURE = 3'd3,
    FINISH  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic               vsync_q, vsync_d, vsync_prev_q, vsync_prev_d;
  logic               href_q, href_d, href_prev_q, href_prev_d;
  logic [7:0]         data_q, data_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic               phase_q, phase_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic               wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic [7:0]         wr_data_q, wr_data_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_line_q, err_line_d;
  logic               err_frame_q, err_frame_d;

  logic vsync_rise_c;
  logic href_fall_c;

  assign vsync_rise_c = vsync_q & ~vsync_prev_q;
  assign href_fall_c  = ~href_q & href_prev_q;

  // State, input stage and output registers.
  always_ff @(posedge pclk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      vsync_q      <= 1'b0;
      vsync_prev_q <= 1'b0;
      href_q       <= 1'b0;
      href_prev_q  <= 1'b0;
      data_q       <= 8'd0;
      row_q        <= '0;
      col_q        <= '0;
      phase_q      <= 1'b0;
      base_q       <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= 8'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_line_q   <= 1'b0;
      err_frame_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      vsync_q      <= vsync_d;
      vsync_prev_q <= vsync_prev_d;
      href_q       <= href_d;
      href_prev_q  <= href_prev_d;
      data_q       <= data_d;
      row_q        <= row_d;
      col_q        <= col_d;
      phase_q      <= phase_d;
      base_q       <= base_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_line_q   <= err_line_d;
      err_frame_q  <= err_frame_d;
    end
  end

  // Next-state, pixel counting and write generation.
  always_comb begin
    state_d      = state_q;
    vsync_d      = bus.vsync;
    href_d       = bus.href;
    data_d       = bus.data;
    vsync_prev_d = vsync_q;
    href_prev_d  = href_q;
    row_d        = row_q;
    col_d        = col_q;
    phase_d      = phase_q;
    base_d       = base_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    err_line_d   = err_line_q;
    err_frame_d  = err_frame_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d     = ARM;
          err_line_d  = 1'b0;
          err_frame_d = 1'b0;
        end
      end
      ARM: begin
        if (bus.abort)         state_d = IDLE;
        else if (vsync_rise_c) state_d = SYNC;
      end
      SYNC: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (!vsync_q) begin
          state_d = CAPTURE;
          row_d   = '0;
          col_d   = '0;
          phase_d = 1'b0;
          base_d  = '0;
        end
      end
      CAPTURE: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else begin
          // Phase is held at Y while href is low, so each line starts on a Y byte.
          phase_d = href_q ? ~phase_q : 1'b0;
          if (href_q && !phase_q && !vsync_rise_c) begin
            if (col_q < COL_W'(WIDTH)) begin
              wr_en_d   = 1'b1;
              wr_data_d = data_q;
              wr_addr_d = base_q + ADDR_W'(col_q);
              col_d     = col_q + COL_W'(1);
            end else begin
              err_line_d = 1'b1;
            end
          end
          // Line completion takes priority over a coincident frame sync.
          if (href_fall_c) begin
            if (col_q != COL_W'(WIDTH)) err_line_d = 1'b1;
            row_d  = row_q + ROW_W'(1);
            col_d  = '0;
            base_d = base_q + ADDR_W'(WIDTH);
            if (row_q == ROW_W'(HEIGHT - 1)) begin
              state_d = FINISH;
            end else if (vsync_rise_c) begin
              err_frame_d = 1'b1;
              state_d     = FINISH;
            end
          end else if (vsync_rise_c) begin
            err_frame_d = 1'b1;
            state_d     = FINISH;
          end
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == FINISH);
  end

  assign bus.wr_en     = wr_en_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err_line  = err_line_q;
  assign bus.err_frame = err_frame_q;

endmodule

// File: doc/ov7642_capture_ctrl.md
OV7642_CAPTURE_CTRL -- requirements
Module: ov7642_capture_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 640, pixels (Y bytes) per line.
REQ-002 SHALL have parameter HEIGHT, default 480, lines per frame.
REQ-003 SHALL have parameter ADDR_W, default 19, frame-buffer address width.
REQ-004 SHALL have ports: pclk  in  1  single clock, all logic on rising edge.
REQ-005 SHALL have ports: n_rst  in  1  asynchronous active-low reset.
REQ-006 SHALL have ports: vsync  in  1  camera frame sync, frame boundary on rising edge.
REQ-007 SHALL have ports: href  in  1  camera line-valid.
REQ-008 SHALL have ports: data  in  8  camera byte stream, order Y, dummy, Y, dummy.
REQ-009 SHALL have ports: start  in  1  one-frame capture request, 1-cycle pulse.
REQ-010 SHALL have ports: abort  in  1  cancel capture.
REQ-011 SHALL have ports: wr_en  out  1  frame-buffer write strobe.
REQ-012 SHALL have ports: wr_addr  out  ADDR_W  write address.
REQ-013 SHALL have ports: wr_data  out  8  Y byte.
REQ-014 SHALL have ports: busy  out  1  high in all states except IDLE.
REQ-015 SHALL have ports: done  out  1  1-cycle pulse at end of capture.
REQ-016 SHALL have ports: err_line  out  1  sticky: line had pixel count other than WIDTH.
REQ-017 SHALL have ports: err_frame  out  1  sticky: frame ended with fewer than HEIGHT lines.

Function
REQ-018 SHALL register vsync, href, data once on pclk (input stage); all decisions use registered copies; edge detect compares registered vs previous registered value.
REQ-019 SHALL implement states IDLE, ARM, SYNC, CAPTURE, FINISH.
REQ-020 IDLE -> ARM on start; start ignored in any other state; start clears err_line and err_frame.
REQ-021 ARM -> SYNC on vsync rising edge.
REQ-022 SYNC -> CAPTURE when registered vsync low; row, col, byte phase cleared on entry.
REQ-023 In CAPTURE, byte phase toggles on every cycle registered href high, starts at Y (phase 0) at each href rising edge.
REQ-024 Phase-0 byte with col < WIDTH: wr_en high 1 cycle, wr_data = byte, wr_addr = row*WIDTH + col, col increments; latency data pin to wr_en = 2 pclk edges.
REQ-025 Phase-0 byte with col >= WIDTH: no write, err_line set.
REQ-026 Phase-1 (dummy) bytes never written.
REQ-027 On href falling edge in CAPTURE: col != WIDTH sets err_line; row increments; col cleared; if row reaches HEIGHT -> FINISH.
REQ-028 vsync rising edge in CAPTURE before HEIGHT lines: err_frame set, -> FINISH; lines in progress discarded (no further writes).
REQ-029 Simultaneous href falling edge completing line HEIGHT and vsync rising edge: completion wins, err_frame not set.
REQ-030 FINISH: done high exactly one cycle, -> IDLE.
REQ-031 abort high in ARM, SYNC or CAPTURE: -> IDLE next cycle, no done, no writes after abort cycle, error flags retained.
REQ-032 wr_addr arithmetic SHALL be ADDR_W bits; WIDTH*HEIGHT-1 SHALL fit ADDR_W (parameter check at elaboration).
REQ-033 href activity outside CAPTURE SHALL produce no writes.

Reset
REQ-034 n_rst low SHALL asynchronously force state IDLE, wr_en 0, wr_addr 0, wr_data 0, busy 0, done 0, err_line 0, err_frame 0, row/col/phase 0, input registers 0.
REQ-035 Reset mid-capture SHALL abandon frame with no done pulse; after release, block idles until next start.

Verification
REQ-036 Full frame WIDTH=8, HEIGHT=4: start, vsync pulse, 4 lines of 16 bytes Y=row*8+col, dummy 0xFF -> 32 writes, addr 0..31, data equals Y, no 0xFF written, done once, errors 0.
REQ-037 Short line: line 2 has 7 Y bytes -> err_line=1, next line starts at addr 24, done still pulses.
REQ-038 Early vsync: vsync rising edge after 2 lines -> err_frame=1, done pulse, writes stop at addr 15.
REQ-039 abort during line 1 -> busy 0 next cycle, no done, no further wr_en; new start then captures next full frame from addr 0.
REQ-040 n_rst asserted mid-line -> all outputs 0 immediately; href without start after release -> zero writes.
